block_cell_painter: RTL and testbench

//  Sits downstream of the game-logic stage. Once per frame it takes the falling piece's four

---
 rtl/block_cell_painter.sv | 134 +++++++++++++
 tb/tb_block_cell_painter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/block_cell_painter.sv
// block_cell_painter: once per frame, erases the falling piece's stale cells and paints its
// current cells into the pixel frame buffer. Each board cell becomes a CELL_PX x CELL_PX block.
//   Clk          system clock
//   Reset        synchronous, active-low
//   frame_start  one-cycle pulse per frame; captured only in IDLE
//   cur_x/cur_y  current cell coordinates (4 cells)
//   prev_x/prev_y previous cell coordinates (4 cells)
//   color        piece palette index
//   fb_addr/fb_data/fb_we  pixel write, held until fb_ready
//   fb_ready     arbiter accepts the write this cycle
//   busy         high from the cycle after capture until done falls
//   done         one-cycle pulse when a frame update completes
//   overrun      sticky; frame_start arrived while busy
// Optional: define CELL_BORDER_EN to draw cell edges with palette index 4'hF.
module block_cell_painter #(
  parameter int unsigned CELL_PX = 16,
  parameter int unsigned BOARD_X0 = 240,
  parameter int unsigned BOARD_Y0 = 80,
  parameter int unsigned H_RES = 640,
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20,
  parameter logic [3:0] BG_COLOR = 4'h0,
  parameter int unsigned FB_AW = 19
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  input  logic [6:0]       cur_x [4],
  input  logic [6:0]       cur_y [4],
  input  logic [6:0]       prev_x [4],
  input  logic [6:0]       prev_y [4],
  input  logic [3:0]       color,
  output logic [FB_AW-1:0] fb_addr,
  output logic [3:0]       fb_data,
  output logic             fb_we,
  input  logic             fb_ready,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  localparam int unsigned PW = $clog2(CELL_PX);
  localparam logic [PW-1:0] PMAX = PW'(CELL_PX - 1);
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
  state_t state;
  logic [6:0] cur_xs [4];
  logic [6:0] cur_ys [4];
  logic [6:0] prev_xs [4];
  logic [6:0] prev_ys [4];
  logic [3:0] color_s, last_color, data_n;
  logic is_static, hit, same, skip, last_pix, adv, load;
  logic [1:0] idx;
  logic [PW-1:0] pix_x, pix_y, ld_x, ld_y;
  logic [6:0] cell_x, cell_y;
  function automatic logic [FB_AW-1:0] pix_addr(logic [6:0] x, logic [6:0] y, logic [PW-1:0] px, logic [PW-1:0] py);
    return FB_AW'((BOARD_Y0 + 32'(y) * CELL_PX + 32'(py)) * H_RES + BOARD_X0 + 32'(x) * CELL_PX + 32'(px));
  endfunction
  always_comb begin
    cell_x = state == DRAW ? cur_xs[idx] : prev_xs[idx];
    cell_y = state == DRAW ? cur_ys[idx] : prev_ys[idx];
    hit = 1'b0;
    same = color == last_color;
    for (int i = 0; i < 4; i++) begin
      hit = hit | (cur_xs[i] == cell_x && cur_ys[i] == cell_y);
      same = same & (cur_x[i] == prev_x[i] && cur_y[i] == prev_y[i]);
    end
    skip = is_static || 32'(cell_x) >= BOARD_W || 32'(cell_y) >= BOARD_H || (state == ERASE && hit);
    last_pix = pix_x == PMAX && pix_y == PMAX;
    // The pixel to present next: origin of a fresh cell, or the successor of the accepted one.
    ld_x = fb_we ? (pix_x == PMAX ? '0 : pix_x + 1'b1) : '0;
    ld_y = fb_we ? (pix_x == PMAX ? pix_y + 1'b1 : pix_y) : '0;
    load = fb_we ? fb_ready && !last_pix : !skip;
    adv = fb_we ? fb_ready && last_pix : skip;
`ifdef CELL_BORDER_EN
    data_n = state != DRAW ? BG_COLOR : (ld_x == '0 || ld_y == '0 || ld_x == PMAX || ld_y == PMAX) ? 4'hF : color_s;
`else
    data_n = state == DRAW ? color_s : BG_COLOR;
`endif
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      fb_we <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      idx <= '0;
      pix_x <= '0;
      pix_y <= '0;
      last_color <= 4'h0;
      is_static <= 1'b0;
    end else begin
      if (frame_start && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (frame_start) begin
          cur_xs <= cur_x;
          cur_ys <= cur_y;
          prev_xs <= prev_x;
          prev_ys <= prev_y;
          color_s <= color;
          is_static <= same;
          busy <= 1'b1;
          idx <= '0;
          state <= ERASE;
        end
        ERASE, DRAW: begin
          if (load) begin
            fb_we <= 1'b1;
            pix_x <= ld_x;
            pix_y <= ld_y;
            fb_addr <= pix_addr(cell_x, cell_y, ld_x, ld_y);
            fb_data <= data_n;
          end
          if (adv) begin
            fb_we <= 1'b0;
            idx <= idx + 2'd1;
            if (idx == 2'd3 && state == ERASE) state <= DRAW;
            if (idx == 2'd3 && state == DRAW) begin
              state <= DONE;
              done <= 1'b1;
              last_color <= color_s;
            end
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_block_cell_painter.sv
// tb_block_cell_painter: scoreboard bench for block_cell_painter with directed frames.
module tb_block_cell_painter;
  logic Clk = 0, Reset = 0, frame_start = 0, fb_ready = 1;
  logic [6:0] cur_x [4];
  logic [6:0] cur_y [4];
  logic [6:0] prev_x [4];
  logic [6:0] prev_y [4];
  logic [3:0] color = 0;
  logic [18:0] fb_addr;
  logic [3:0] fb_data;
  logic fb_we, busy, done, overrun;
  typedef struct packed {logic [18:0] a; logic [3:0] d;} wr_t;
  wr_t expq[$];
  wr_t e;
  int vectors = 0, errors = 0, cyc = 0;
  int wr_cnt = 0, done_cyc = 0, last_wr_cyc = 0, start_cyc = 0;
  logic [18:0] first_addr, addr16, addr256, hold_a;
  logic [3:0] hold_d;
  bit done_seen = 0, pend = 0;
  logic [3:0] model_last = 0;

  block_cell_painter dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .cur_x(cur_x), .cur_y(cur_y), .prev_x(prev_x), .prev_y(prev_y), .color(color),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      if (pend) begin
        check("hold_we", fb_we, 1);
        check("hold_addr", fb_addr, hold_a);
        check("hold_data", fb_data, hold_d);
      end
      pend = fb_we && !fb_ready;
      hold_a = fb_addr;
      hold_d = fb_data;
      if (fb_we && fb_ready) begin
        if (wr_cnt == 0) first_addr = fb_addr;
        if (wr_cnt == 15) addr16 = fb_addr;
        if (wr_cnt == 255) addr256 = fb_addr;
        wr_cnt++;
        last_wr_cyc = cyc;
        if (expq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL extra_write: got addr %0d data %0h expected no write", fb_addr, fb_data);
        end else begin
          e = expq.pop_front();
          check("wr_addr", fb_addr, e.a);
          check("wr_data", fb_data, e.d);
        end
      end
      if (done) begin
        done_seen = 1;
        done_cyc = cyc;
      end
    end else pend = 0;
  end

  function automatic logic [18:0] paddr(int x, int y, int px, int py);
    return 19'((80 + y * 16 + py) * 640 + 240 + x * 16 + px);
  endfunction

  task automatic set_cells(input int p[8], input int c[8], input logic [3:0] col);
    for (int i = 0; i < 4; i++) begin
      prev_x[i] = 7'(p[2*i]);
      prev_y[i] = 7'(p[2*i+1]);
      cur_x[i] = 7'(c[2*i]);
      cur_y[i] = 7'(c[2*i+1]);
    end
    color = col;
  endtask

  task automatic push_expected();
    bit st, hit;
    logic [3:0] d;
    st = color == model_last;
    for (int i = 0; i < 4; i++) if (cur_x[i] != prev_x[i] || cur_y[i] != prev_y[i]) st = 0;
    if (st) return;
    for (int i = 0; i < 4; i++) begin
      hit = 0;
      for (int j = 0; j < 4; j++) if (cur_x[j] == prev_x[i] && cur_y[j] == prev_y[i]) hit = 1;
      if (prev_x[i] < 10 && prev_y[i] < 20 && !hit)
        for (int py = 0; py < 16; py++)
          for (int px = 0; px < 16; px++) expq.push_back({paddr(prev_x[i], prev_y[i], px, py), 4'h0});
    end
    for (int i = 0; i < 4; i++)
      if (cur_x[i] < 10 && cur_y[i] < 20)
        for (int py = 0; py < 16; py++)
          for (int px = 0; px < 16; px++) begin
            d = color;
`ifdef CELL_BORDER_EN
            if (px == 0 || py == 0 || px == 15 || py == 15) d = 4'hF;
`endif
            expq.push_back({paddr(cur_x[i], cur_y[i], px, py), d});
          end
  endtask

  task automatic start_frame();
    push_expected();
    wr_cnt = 0;
    done_seen = 0;
    frame_start = 1;
    start_cyc = cyc;
    @(posedge Clk);
    #1 frame_start = 0;
  endtask

  task automatic run_frame(input bit toggle, input int exp_writes, input bit pulse, input int exp_rel);
    int k;
    start_frame();
    k = 0;
    while (!done_seen && k < 5000) begin
      frame_start = pulse && k == 100;
      if (toggle) fb_ready = ~fb_ready;
      @(posedge Clk);
      #1 k++;
    end
    frame_start = 0;
    fb_ready = 1;
    check("done_seen", done_seen, 1);
    check("write_count", wr_cnt, exp_writes);
    check("queue_left", expq.size(), 0);
    if (exp_writes > 0) check("done_after_last_write", done_cyc - last_wr_cyc, 1);
    if (exp_rel > 0) check("done_cycle", done_cyc - start_cyc, exp_rel);
    check("busy_after_done", busy, 0);
    check("done_pulse_width", done, 0);
    expq.delete();
    model_last = color;
  endtask

  int o_prev[8] = '{4, 0, 5, 0, 4, 1, 5, 1};
  int o_cur[8] = '{4, 1, 5, 1, 4, 2, 5, 2};
  int off_prev[8] = '{10, 0, 0, 20, 12, 3, 3, 25};
  int off_cur[8] = '{9, 19, 10, 0, 0, 20, 0, 0};

  initial begin
    int k;
    for (int i = 0; i < 4; i++) begin
      cur_x[i] = 0; cur_y[i] = 0; prev_x[i] = 0; prev_y[i] = 0;
    end
    repeat (3) @(posedge Clk);
    #1;
    check("rst_we", fb_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    Reset = 1;
    @(posedge Clk);
    #1;
    set_cells(o_prev, o_cur, 4'h2);
    run_frame(0, 1536, 0, 0);
    check("first_erase_addr", first_addr, 51504);
    check("row0_last_addr", addr16, 51519);
    check("cell_last_addr", addr256, 61119);
    set_cells(o_cur, o_cur, 4'h2);
    run_frame(0, 0, 0, 9);
    set_cells(o_prev, o_cur, 4'h2);
    run_frame(1, 1536, 0, 0);
    set_cells(off_prev, off_cur, 4'h5);
    run_frame(0, 512, 0, 0);
    check("overrun_before", overrun, 0);
    set_cells(o_prev, o_cur, 4'h2);
    run_frame(0, 1536, 1, 0);
    check("overrun_set", overrun, 1);
    repeat (20) @(posedge Clk);
    #1;
    check("no_recapture_writes", wr_cnt, 1536);
    check("overrun_sticky", overrun, 1);
    check("idle_busy", busy, 0);
    start_frame();
    k = 0;
    while (wr_cnt < 700 && k < 3000) begin
      @(posedge Clk);
      #1 k++;
    end
    check("reached_draw", wr_cnt >= 700, 1);
    Reset = 0;
    @(posedge Clk);
    #1 Reset = 1;
    check("midrst_we", fb_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    expq.delete();
    model_last = 0;
    @(posedge Clk);
    #1;
    run_frame(0, 1536, 0, 0);
    check("post_reset_overrun", overrun, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
